// File: rtl/multiplier_issue_unit.sv
// Issue/collect sequencer for a shift-and-add multiplier core: takes operand pairs,
// starts the core, captures its product (or a watchdog timeout) and re-arms it.
module multiplier_issue_unit #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                 clock,
   input  logic                 n_reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_multiplicand,
   input  logic [WIDTH-1:0]     in_multiplier,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic                 out_error,
   output logic                 core_n_reset,
   output logic                 core_start,
   input  logic                 core_ready,
   output logic [WIDTH-1:0]     core_multiplicand,
   output logic [WIDTH-1:0]     core_multiplier,
   input  logic [2*WIDTH-1:0]   core_product
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      OUT,
      CLEAR,
      RECOVER
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     waitCount_q, waitCount_d;
   logic [WIDTH-1:0]     multiplicand_q, multiplicand_d;
   logic [WIDTH-1:0]     multiplier_q, multiplier_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 error_q, error_d;
   logic                 coreNReset_q, coreNReset_d;

   // State, operand, result and core-reset registers.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q        <= IDLE;
         waitCount_q    <= '0;
         multiplicand_q <= '0;
         multiplier_q   <= '0;
         product_q      <= '0;
         error_q        <= 1'b0;
         coreNReset_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         waitCount_q    <= waitCount_d;
         multiplicand_q <= multiplicand_d;
         multiplier_q   <= multiplier_d;
         product_q      <= product_d;
         error_q        <= error_d;
         coreNReset_q   <= coreNReset_d;
      end
   end

   // Next-state logic; core_ready is only honoured in WAIT and beats the watchdog.
   always_comb begin
      state_d        = state_q;
      waitCount_d    = waitCount_q;
      multiplicand_d = multiplicand_q;
      multiplier_d   = multiplier_q;
      product_d      = product_q;
      error_d        = error_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               multiplicand_d = in_multiplicand;
               multiplier_d   = in_multiplier;
               state_d        = START;
            end
         end
         START: begin
            waitCount_d = '0;
            state_d     = WAIT;
         end
         WAIT: begin
            waitCount_d = waitCount_q + 1'b1;
            if (core_ready) begin
               product_d = core_product;
               error_d   = 1'b0;
               state_d   = OUT;
            end else if (waitCount_q == LAST_COUNT) begin
               product_d = '0;
               error_d   = 1'b1;
               state_d   = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               state_d = CLEAR;
            end
         end
         CLEAR:   state_d = RECOVER;
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Registered from the next state so the core reset is clean and lasts exactly one cycle.
      coreNReset_d = (state_d != CLEAR);
   end

   assign in_ready          = (state_q == IDLE);
   assign core_start        = (state_q == START);
   assign out_valid         = (state_q == OUT);
   assign out_product       = product_q;
   assign out_error         = error_q;
   assign core_n_reset      = coreNReset_q;
   assign core_multiplicand = multiplicand_q;
   assign core_multiplier   = multiplier_q;

endmodule
